// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - round/match score keeper with board-clear handshake
//
// Purpose: counts green/red round wins for the HEX display, runs a board-clear
// handshake after every round, holds the match-over state until a new match is
// requested, and tracks which colour moves first in the next round.
//
// Ports:
//   clk          system clock, rising edge
//   RST          asynchronous active-low reset
//   win_g/win_r  win-detect levels (four in a row) for green/red
//   new_match    debounced key level: start a new match
//   board_ack    board reports its clear is complete
//   scoreG/R     round wins, 0..WIN_SCORE
//   clear_req    request to the board to clear all cells
//   match_over   high while the match is decided
//   first_green  1 = green moves first in the next round
//   ack_fault    sticky: a clear request timed out
module score_keeper #(
  parameter int WIN_SCORE   = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       win_g,
  input  logic       win_r,
  input  logic       new_match,
  input  logic       board_ack,
  output logic [2:0] scoreG,
  output logic [2:0] scoreR,
  output logic       clear_req,
  output logic       match_over,
  output logic       first_green,
  output logic       ack_fault
);

  // Counter only has to reach ACK_TIMEOUT-1: the last waiting cycle is the
  // one in which the timeout is taken.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [2:0]    WIN  = 3'(WIN_SCORE);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CLEAR = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    score_g_q, score_g_d;
  logic [2:0]    score_r_q, score_r_d;
  logic          fg_q, fg_d;
  logic          fault_q, fault_d;

  // Sample register plus previous-sample register per input; the rise is
  // judged on registered values, so actions land two clocks after the input.
  logic g_s, g_p, r_s, r_p, nm_s, nm_p;
  logic g_ev, r_ev, nm_ev;

  assign g_ev  = g_s  & ~g_p;
  assign r_ev  = r_s  & ~r_p;
  assign nm_ev = nm_s & ~nm_p;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_g_d = score_g_q;
    score_r_d = score_r_q;
    fg_d      = fg_q;
    fault_d   = fault_q;
    case (state_q)
      S_PLAY: begin
        // new_match wins over any coincident round result
        if (nm_ev) begin
          score_g_d = 3'd0;
          score_r_d = 3'd0;
          fg_d      = 1'b1;
          state_d   = S_CLEAR;
        end else if (g_ev && r_ev) begin
          fg_d    = ~fg_q;
          state_d = S_CLEAR;
        end else if (g_ev) begin
          if (score_g_q < WIN) score_g_d = score_g_q + 3'd1;
          fg_d    = 1'b0;
          state_d = S_CLEAR;
        end else if (r_ev) begin
          if (score_r_q < WIN) score_r_d = score_r_q + 3'd1;
          fg_d    = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // A timeout leaves exactly like an ack, only flagging the fault.
        if (board_ack || (cnt_q == LAST)) begin
          if (!board_ack) fault_d = 1'b1;
          cnt_d   = '0;
          state_d = ((score_g_q == WIN) || (score_r_q == WIN)) ? S_OVER : S_PLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OVER: begin
        if (nm_ev) begin
          score_g_d = 3'd0;
          score_r_d = 3'd0;
          fg_d      = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= S_PLAY;
      cnt_q     <= '0;
      score_g_q <= 3'd0;
      score_r_q <= 3'd0;
      fg_q      <= 1'b1;
      fault_q   <= 1'b0;
      g_s       <= 1'b0;
      g_p       <= 1'b0;
      r_s       <= 1'b0;
      r_p       <= 1'b0;
      nm_s      <= 1'b0;
      nm_p      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_g_q <= score_g_d;
      score_r_q <= score_r_d;
      fg_q      <= fg_d;
      fault_q   <= fault_d;
      g_s       <= win_g;
      g_p       <= g_s;
      r_s       <= win_r;
      r_p       <= r_s;
      nm_s      <= new_match;
      nm_p      <= nm_s;
    end
  end

  assign scoreG      = score_g_q;
  assign scoreR      = score_r_q;
  assign clear_req   = (state_q == S_CLEAR);
  assign match_over  = (state_q == S_OVER);
  assign first_green = fg_q;
  assign ack_fault   = fault_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

  localparam int WIN = 5;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       win_g = 1'b0, win_r = 1'b0, new_match = 1'b0, board_ack = 1'b0;
  logic [2:0] scoreG, scoreR;
  logic       clear_req, match_over, first_green, ack_fault;

  int checks = 0;
  int errors = 0;

  score_keeper #(.WIN_SCORE(WIN), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .RST(RST), .win_g(win_g), .win_r(win_r),
    .new_match(new_match), .board_ack(board_ack),
    .scoreG(scoreG), .scoreR(scoreR), .clear_req(clear_req),
    .match_over(match_over), .first_green(first_green), .ack_fault(ack_fault)
  );

  always #5 clk = ~clk;

  // Reference model: match bookkeeping in plain integers and flags.
  int m_sg, m_sr, m_wait;
  bit m_busy, m_decided, m_fg, m_fault;
  bit seen_g, prev_g, seen_r, prev_r, seen_n, prev_n;

  function automatic void model_reset();
    m_sg = 0; m_sr = 0; m_wait = 0;
    m_busy = 0; m_decided = 0; m_fg = 1; m_fault = 0;
    seen_g = 0; prev_g = 0; seen_r = 0; prev_r = 0; seen_n = 0; prev_n = 0;
  endfunction

  function automatic void model_step();
    bit eg, er, en;
    if (!RST) begin
      model_reset();
    end else begin
      eg = seen_g && !prev_g;
      er = seen_r && !prev_r;
      en = seen_n && !prev_n;
      if (m_busy) begin
        m_wait++;
        if (board_ack || m_wait == TMO) begin
          if (!board_ack) m_fault = 1;
          m_busy = 0;
          m_wait = 0;
          m_decided = (m_sg == WIN) || (m_sr == WIN);
        end
      end else if (en) begin
        m_sg = 0; m_sr = 0; m_fg = 1; m_decided = 0; m_busy = 1;
      end else if (!m_decided && (eg || er)) begin
        if (eg && er) m_fg = !m_fg;
        else if (eg) begin m_sg = (m_sg < WIN) ? m_sg + 1 : m_sg; m_fg = 0; end
        else begin m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_fg = 1; end
        m_busy = 1;
      end
      prev_g = seen_g; seen_g = win_g;
      prev_r = seen_r; seen_r = win_r;
      prev_n = seen_n; seen_n = new_match;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_scoreG", 32'(scoreG), 32'(m_sg));
    chk("model_scoreR", 32'(scoreR), 32'(m_sr));
    chk("model_clear_req", 32'(clear_req), 32'(m_busy));
    chk("model_match_over", 32'(match_over), 32'(m_decided));
    chk("model_first_green", 32'(first_green), 32'(m_fg));
    chk("model_ack_fault", 32'(ack_fault), 32'(m_fault));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Wait (bounded) for clear_req, then return ack after 'delay' cycles.
  task automatic ack_round(input int delay);
    int k;
    k = 0;
    while (!clear_req && k < 20) begin
      tick();
      k++;
    end
    chk("clear_req_seen", 32'(clear_req), 32'd1);
    ticks(delay);
    board_ack = 1'b1;
    tick();
    board_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_scoreG"}, 32'(scoreG), 32'd0);
    chk({tag, "_scoreR"}, 32'(scoreR), 32'd0);
    chk({tag, "_clear_req"}, 32'(clear_req), 32'd0);
    chk({tag, "_match_over"}, 32'(match_over), 32'd0);
    chk({tag, "_first_green"}, 32'(first_green), 32'd1);
    chk({tag, "_ack_fault"}, 32'(ack_fault), 32'd0);
  endtask

  initial begin
    int hi;
    model_reset();

    // Reset
    ticks(2);
    check_reset_values("reset");
    RST = 1'b1;
    tick();

    // 1: single green win, ack three cycles into the clear
    win_g = 1'b1; tick(); win_g = 1'b0;
    hi = 0;
    repeat (3) begin tick(); if (clear_req) hi++; end
    board_ack = 1'b1; tick(); board_ack = 1'b0;
    chk("t1_clear_cycles", hi, 3);
    chk("t1_clear_low", 32'(clear_req), 32'd0);
    chk("t1_scoreG", 32'(scoreG), 32'd1);
    chk("t1_first_green", 32'(first_green), 32'd0);
    chk("t1_match_over", 32'(match_over), 32'd0);

    // 2: win_r held for 20 cycles counts once
    win_r = 1'b1;
    repeat (20) begin board_ack = clear_req; tick(); end
    win_r = 1'b0; board_ack = 1'b0;
    ticks(3);
    chk("t2_scoreR", 32'(scoreR), 32'd1);
    chk("t2_first_green", 32'(first_green), 32'd1);

    // 3: simultaneous wins are a draw
    win_g = 1'b1; win_r = 1'b1; tick(); win_g = 1'b0; win_r = 1'b0; tick();
    chk("t3_clear_req", 32'(clear_req), 32'd1);
    chk("t3_scoreG", 32'(scoreG), 32'd1);
    chk("t3_scoreR", 32'(scoreR), 32'd1);
    chk("t3_first_green", 32'(first_green), 32'd0);
    ack_round(1);

    // 4: abort to 0/0, then five green wins decide the match
    new_match = 1'b1; tick(); new_match = 1'b0; tick();
    chk("t4_abort_scoreG", 32'(scoreG), 32'd0);
    chk("t4_abort_clear", 32'(clear_req), 32'd1);
    ack_round(0);
    for (int i = 0; i < 5; i++) begin
      win_g = 1'b1; tick(); win_g = 1'b0;
      ack_round(2);
    end
    chk("t4_scoreG_win", 32'(scoreG), 32'd5);
    chk("t4_match_over", 32'(match_over), 32'd1);
    win_r = 1'b1; tick(); win_r = 1'b0; ticks(4);
    chk("t4_frozen_scoreR", 32'(scoreR), 32'd0);
    chk("t4_still_over", 32'(match_over), 32'd1);
    new_match = 1'b1; tick(); new_match = 1'b0; tick();
    chk("t4_new_scoreG", 32'(scoreG), 32'd0);
    chk("t4_new_scoreR", 32'(scoreR), 32'd0);
    chk("t4_new_over", 32'(match_over), 32'd0);
    chk("t4_new_first_green", 32'(first_green), 32'd1);
    chk("t4_new_clear", 32'(clear_req), 32'd1);
    ack_round(1);

    // 5: no ack -> timeout after TMO clear cycles
    chk("t5_fault_before", 32'(ack_fault), 32'd0);
    win_g = 1'b1; tick(); win_g = 1'b0;
    hi = 0;
    repeat (30) begin tick(); if (clear_req) hi++; end
    chk("t5_clear_cycles", hi, TMO);
    chk("t5_ack_fault", 32'(ack_fault), 32'd1);
    chk("t5_clear_low", 32'(clear_req), 32'd0);
    chk("t5_play", 32'(match_over), 32'd0);
    chk("t5_scoreG", 32'(scoreG), 32'd1);
    win_r = 1'b1; tick(); win_r = 1'b0;
    ack_round(1);
    chk("t5_next_win", 32'(scoreR), 32'd1);
    chk("t5_fault_sticky", 32'(ack_fault), 32'd1);

    // 6: asynchronous reset in the middle of a clear with scoreG=3
    win_g = 1'b1; tick(); win_g = 1'b0;
    ack_round(1);
    win_g = 1'b1; tick(); win_g = 1'b0; tick(); tick();
    chk("t6_scoreG", 32'(scoreG), 32'd3);
    chk("t6_in_clear", 32'(clear_req), 32'd1);
    #2 RST = 1'b0;
    #1 check_reset_values("t6_async");
    model_reset();
    tick();
    RST = 1'b1;
    tick();
    check_reset_values("t6_after");

    // Randomized traffic against the model
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) win_g = ~win_g;
      if ($urandom_range(0, 5) == 0) win_r = ~win_r;
      if ($urandom_range(0, 25) == 0) new_match = ~new_match;
      board_ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Produces the 3-bit green/red match scores that the HEX display block consumes; a score of 5 on either side is the match-won indication.
- Sits between the 16x16 board/win-detect logic and the display block.
- Counts round wins, runs a board-clear handshake after every round, and holds the match-over state until a new match is requested.
- Tracks which colour moves first in the next round.

Parameters:
- WIN_SCORE, 5, round wins needed to take the match. Legal range 1..7.
- ACK_TIMEOUT, 255, cycles to wait for board_ack before abandoning a clear request. Must be 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous, active-low.
- win_g  input  1  level from win-detect: green has four in a row.
- win_r  input  1  level from win-detect: red has four in a row.
- new_match  input  1  level from a debounced key: start a new match.
- board_ack  input  1  board reports its clear is complete.
- scoreG  output  3  green round wins, 0..WIN_SCORE.
- scoreR  output  3  red round wins, 0..WIN_SCORE.
- clear_req  output  1  request to the board to clear all cells.
- match_over  output  1  high while the match is decided.
- first_green  output  1  1 means green moves first in the next round.
- ack_fault  output  1  sticky flag: a clear request timed out.

Behaviour:
- Reset (RST low, asynchronous; held regardless of clk):
  - scoreG=0, scoreR=0, clear_req=0, match_over=0, first_green=1, ack_fault=0.
  - State=PLAY, timeout counter=0, all edge-detect registers=0.
- Input edge detection:
  - win_g, win_r and new_match are each registered once.
  - An event is input high and previous sample low.
  - A level held high counts once.
- States:
  - PLAY: accepts round results.
  - CLEAR: clear_req=1, waits for the board.
  - OVER: match_over=1.
- PLAY, rise on win_g only:
  - scoreG increments at the same clock edge; first_green<=0 (the loser, red, moves first).
  - Goes to CLEAR.
- PLAY, rise on win_r only:
  - Symmetric: scoreR increments and first_green<=1.
- PLAY, both rise in the same cycle:
  - Treated as a draw; no score change and first_green toggles.
  - Goes to CLEAR.
- Output timing: the score change and clear_req are visible the cycle after the edge is detected. Latency is 2 clocks from an input rising to scoreX changing.
- CLEAR:
  - The counter increments every cycle.
  - board_ack sampled high: clear_req drops on the next edge and the counter resets.
  - Next state is OVER if scoreG==WIN_SCORE or scoreR==WIN_SCORE, otherwise PLAY.
  - Counter reaches ACK_TIMEOUT with no ack: set ack_fault, then leave exactly as if ack had arrived.
  - Win and new_match edges arriving in CLEAR are discarded, not queued.
- Scores never exceed WIN_SCORE and never wrap. The increment that reaches WIN_SCORE is the last one until a new match.
- OVER:
  - Scores are frozen; win edges are ignored.
  - A new_match rise zeroes both scores, drops match_over, sets first_green=1, and goes to CLEAR.
  - ack_fault stays set (only RST clears it).
- A new_match rise in PLAY also zeroes the scores, sets first_green=1, and enters CLEAR (match abort).
- If a new_match rise and a win rise coincide in PLAY, new_match takes priority and no score is incremented.
- board_ack high outside CLEAR is ignored.
- RST asserted mid-handshake: clear_req drops immediately (asynchronously); no state is retained.

Test Plan:
1. Reset, then pulse win_g high for 1 cycle with ack returned 3 cycles later:
   - scoreG=1, first_green=0.
   - clear_req high for exactly the cycles until ack is sampled, then low; state back in PLAY.
2. Hold win_r high for 20 cycles across the clear:
   - scoreR increments exactly once to 1.
3. Raise win_g and win_r in the same cycle:
   - Scores unchanged, first_green toggles, clear_req asserts.
4. Five green wins, each acked:
   - scoreG=5 and match_over=1 after the fifth ack.
   - A further win_r pulse leaves scoreR unchanged.
   - A new_match pulse gives scores 0/0, match_over=0, first_green=1, and clear_req=1.
5. Win with board_ack tied low and ACK_TIMEOUT=8:
   - clear_req drops after 8 CLEAR cycles, ack_fault=1, state is PLAY.
   - A subsequent win still counts.
6. Drive RST low asynchronously mid-CLEAR with scoreG=3:
   - All outputs return to their reset values before the next clk edge.
